affine_controller_nd: RTL and testbench
=======================================

Name: affine_controller_nd

Overview:
- Parametrised N-dimensional affine schedule controller. Successor to the fixed 3-D per-op controllers in the generated collateral.
- Emits the iteration-domain indices of one compute op, plus a valid strobe, at cycle `START + Σ STRIDE[i]*d[i]`.
- Adds a stall input, a synchronous flush/restart, a done indication, and optional periodic repeat.
- Instantiated once per op; drives the op's buffer ports.

Parameters:
- NDIM, 3: loop dimensions, 1..4. d[0] is outermost.
- W, 16: index width.
- TW, 32: schedule-time counter width.
- START, 0: cycle of the first point.
- EXTENT, {64,64,64} packed NDIM*W: trip count per dimension, each ≥1.
- STRIDE, {4096,64,1} packed NDIM*TW: cycles per increment of d[i]. Requirement: STRIDE[i] ≥ EXTENT[i+1]*STRIDE[i+1]; elaboration error otherwise.
- REPEAT, 0: 0 = one-shot, 1 = schedule repeats every PERIOD cycles.
- PERIOD, 262144: repeat period. Must exceed last-point offset (`Σ(EXTENT[i]-1)*STRIDE[i]`); elaboration error otherwise.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- flush, input, 1: synchronous restart, highest priority after reset.
- en, input, 1: advance enable; low = stall.
- d, output, NDIM x W: current/last iteration indices, d[0] outermost.
- valid, output, 1: point issued this cycle.
- done, output, 1: completion indication.

Behaviour:
- Active cycle: a rising edge with en=1 and flush=0. Cycle c = index of active cycles since reset release or the last flush; first is c=0.
- States:
  - DELAY: waits START active cycles. Skipped if START=0.
  - RUN: issues points.
  - DONE: one-shot only.
- valid = 1 in active cycle c exactly when `c == START + Σ STRIDE[i]*d[i]` for the next unissued point. Points are issued in lexicographic order (innermost d[NDIM-1] fastest).
- valid is combinational from registered state and is gated by en. With en=0, valid=0 and all state holds; a pending point issues on the next en=1 cycle.
- d presents the point's indices in its valid cycle and holds them until the next point. Before the first point d=0.
- Wrap: when d[i] reaches EXTENT[i]-1 and advances, d[i]←0 and d[i-1] increments. EXTENT[i]=1 means d[i] is always 0.
- Schedule time is tracked in TW bits. Implementation choice: incremental next-target register, or per-dimension gap counters. No overflow is permitted for legal parameters.
- One-shot (REPEAT=0):
  - After the last point (all d[i]=EXTENT[i]-1) → DONE.
  - done=1 from the next cycle on; level, held until flush or reset.
  - valid stays 0 and d holds the last point.
- Repeat (REPEAT=1):
  - Iteration k issues points at `START + k*PERIOD + offset`.
  - The initial delay of START applies once.
  - done is a 1-cycle pulse in the active cycle after each iteration's last point. It is gated by en like valid.
  - d resets to 0 on the next iteration's first point.
- flush=1 at an edge (regardless of en): state→DELAY (or RUN if START=0), c=0, d=0, done=0. valid=0 in the flush cycle. The next cycle is c=0.
- Reset values: valid=0, done=0, d=0, state per START, time counters 0. Reset mid-run aborts immediately.
- NDIM=1 is legal: a single strided counter.

Test Plan:
- NDIM=2, EXTENT={4,3}, STRIDE={8,1}, START=5, en=1 → valid in cycles 5-7, 13-15, 21-23, 29-31 with d=(0,0)…(3,2); done=1 from cycle 32 and held; 12 valid pulses total.
- Same config, en=0 in cycles 6-9 → point (0,1) issued at wall cycle 10, all later points shifted by 4; d stable during the stall.
- Same config, flush in cycle 20 → no valid in cycle 20; valid resumes with d=(0,0) at wall cycle 26, i.e. c=5 after the flush.
- REPEAT=1, PERIOD=40, same config → second iteration's first point at cycle 45; done pulses at cycles 32 and 72; d returns to (0,0) at cycle 45.
- Default 3-D, START=0 → valid in cycle 0 with d=0; point (0,1,0) at cycle 64; last point (63,63,63) at 262143; done at 262144.
- rst_n low in cycle 14, released later → valid/done/d all 0 immediately; schedule restarts from c=0 after release.

Source files
------------

// File: rtl/affine_controller_nd.sv
// affine_controller_nd: N-dimensional affine schedule controller issuing loop indices at their scheduled cycles
module affine_controller_nd #(
  parameter int NDIM = 3,
  parameter int W = 16,
  parameter int TW = 32,
  parameter logic [TW-1:0] START = '0,
  parameter logic [NDIM*W-1:0] EXTENT = {16'd64, 16'd64, 16'd64},
  parameter logic [NDIM*TW-1:0] STRIDE = {32'd4096, 32'd64, 32'd1},
  parameter bit REPEAT = 1'b0,
  parameter logic [TW-1:0] PERIOD = TW'(262144)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                en,
  output logic [NDIM*W-1:0]   d,
  output logic                valid,
  output logic                done
);
  typedef enum logic [1:0] {S_DELAY, S_RUN, S_DONE} state_t;
  function automatic logic [W-1:0] ext_of(int i);
    return EXTENT[(NDIM-1-i)*W +: W];
  endfunction
  function automatic logic [TW-1:0] stride_of(int i);
    return STRIDE[(NDIM-1-i)*TW +: TW];
  endfunction
  // offset contributed by dimensions j..NDIM-1 when each sits at its last index
  function automatic logic [TW-1:0] tail_of(int j);
    logic [TW-1:0] s;
    s = '0;
    for (int i = j; i < NDIM; i++) s = s + (TW'(ext_of(i)) - 1'b1) * stride_of(i);
    return s;
  endfunction
  localparam logic [TW-1:0] LAST = tail_of(0);
  localparam logic [TW-1:0] WRAP_GAP = PERIOD - LAST;
  localparam state_t S_INIT = (START == '0) ? S_RUN : S_DELAY;
  if (NDIM < 1 || NDIM > 4) begin : g_bad_ndim
    $error("affine_controller_nd: NDIM must be 1..4");
  end
  for (genvar g = 0; g < NDIM; g++) begin : g_chk
    if (ext_of(g) == '0) begin : g_bad_ext
      $error("affine_controller_nd: EXTENT must be >= 1");
    end
    if (g < NDIM - 1) begin : g_ord
      if (longint'(stride_of(g)) < longint'(ext_of(g + 1)) * longint'(stride_of(g + 1))) begin : g_bad_stride
        $error("affine_controller_nd: STRIDE[i] must cover EXTENT[i+1]*STRIDE[i+1]");
      end
    end
  end
  if (REPEAT && PERIOD <= LAST) begin : g_bad_period
    $error("affine_controller_nd: PERIOD must exceed the last-point offset");
  end
  state_t             r_state;
  logic [TW-1:0]      r_wait;
  logic [NDIM*W-1:0]  r_pt;
  logic [NDIM*W-1:0]  r_d;
  logic               r_done;
  logic [NDIM*W-1:0]  w_nxt;
  logic [TW-1:0]      w_gap;
  logic               w_last;
  logic               w_pend;
  logic               w_act;
  // lexicographic successor of the pending point and the cycle gap to it; w_last marks the final point
  always_comb begin
    w_nxt = r_pt;
    w_gap = WRAP_GAP;
    w_last = 1'b1;
    for (int i = NDIM - 1; i >= 0; i--) begin
      if (w_last) begin
        if (r_pt[(NDIM-1-i)*W +: W] == ext_of(i) - 1'b1) w_nxt[(NDIM-1-i)*W +: W] = '0;
        else begin
          w_nxt[(NDIM-1-i)*W +: W] = r_pt[(NDIM-1-i)*W +: W] + 1'b1;
          w_gap = stride_of(i) - tail_of(i + 1);
          w_last = 1'b0;
        end
      end
    end
  end
  assign w_pend = (r_state != S_DONE) && (r_wait == '0);
  assign w_act = en && !flush && rst_n;
  assign valid = w_act && w_pend;
  assign d = valid ? r_pt : r_d;
  assign done = REPEAT ? (w_act && r_done) : r_done;
  // countdown to the pending point; on issue, latch it and load the gap to its successor
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INIT;
      r_wait <= START;
      r_pt <= '0;
      r_d <= '0;
      r_done <= 1'b0;
    end else if (flush) begin
      r_state <= S_INIT;
      r_wait <= START;
      r_pt <= '0;
      r_d <= '0;
      r_done <= 1'b0;
    end else if (en) begin
      if (w_pend) begin
        r_d <= r_pt;
        r_pt <= w_nxt;
        r_wait <= w_gap - 1'b1;
        r_state <= (!REPEAT && w_last) ? S_DONE : S_RUN;
      end else if (r_state != S_DONE) r_wait <= r_wait - 1'b1;
      r_done <= REPEAT ? (w_pend && w_last) : (r_done || (w_pend && w_last));
    end
  end
endmodule

// File: tb/tb_affine_controller_nd.sv
// tb_affine_controller_nd: table, directed and randomized checks of four controller configurations against an arithmetic schedule model
module tb_affine_controller_nd;
  logic clk = 1'b0;
  logic rst_n, flush, en;
  logic [31:0] d_a, d_b;
  logic [47:0] d_c;
  logic [15:0] d_d;
  logic [3:0] v, dn;
  logic [63:0] dut_d [4];
  always #5 clk = ~clk;
  affine_controller_nd #(.NDIM(2), .START(32'd5), .EXTENT({16'd4, 16'd3}), .STRIDE({32'd8, 32'd1}), .REPEAT(1'b0))
    u_a (.clk(clk), .rst_n(rst_n), .flush(flush), .en(en), .d(d_a), .valid(v[0]), .done(dn[0]));
  affine_controller_nd #(.NDIM(2), .START(32'd5), .EXTENT({16'd4, 16'd3}), .STRIDE({32'd8, 32'd1}), .REPEAT(1'b1), .PERIOD(32'd40))
    u_b (.clk(clk), .rst_n(rst_n), .flush(flush), .en(en), .d(d_b), .valid(v[1]), .done(dn[1]));
  affine_controller_nd #(.NDIM(3), .START(32'd0), .EXTENT({16'd2, 16'd3, 16'd4}), .STRIDE({32'd40, 32'd12, 32'd3}), .REPEAT(1'b1), .PERIOD(32'd80))
    u_c (.clk(clk), .rst_n(rst_n), .flush(flush), .en(en), .d(d_c), .valid(v[2]), .done(dn[2]));
  affine_controller_nd #(.NDIM(1), .START(32'd3), .EXTENT(16'd5), .STRIDE(32'd2), .REPEAT(1'b0))
    u_d (.clk(clk), .rst_n(rst_n), .flush(flush), .en(en), .d(d_d), .valid(v[3]), .done(dn[3]));
  assign dut_d[0] = 64'(d_a);
  assign dut_d[1] = 64'(d_b);
  assign dut_d[2] = 64'(d_c);
  assign dut_d[3] = 64'(d_d);
  int cf_nd [4] = '{2, 2, 3, 1};
  int cf_e [4][4] = '{'{4, 3, 1, 1}, '{4, 3, 1, 1}, '{2, 3, 4, 1}, '{5, 1, 1, 1}};
  int cf_s [4][4] = '{'{8, 1, 1, 1}, '{8, 1, 1, 1}, '{40, 12, 3, 1}, '{2, 1, 1, 1}};
  int cf_start [4] = '{5, 5, 0, 3};
  bit cf_rep [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  int cf_per [4] = '{1, 40, 80, 1};
  int mc [4];
  int md [4][4];
  bit mf [4];
  bit h_hit [4];
  bit h_last [4];
  int h_idx [4][4];
  logic s_v [4];
  logic s_dn [4];
  logic [63:0] s_d [4];
  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int nv_a = 0;
  bit tbl_on = 1'b0;
  typedef struct packed {
    int cyc;
    bit av;
    bit adn;
    logic [31:0] ad;
    bit bv;
    bit bdn;
    logic [31:0] bd;
  } vec_t;
  vec_t tbl [12];
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h t=%0t", nm, cyc, got, exp, $time);
    end
  endtask
  // a point is due at active cycle c when c-START (mod PERIOD) decomposes exactly into in-range indices
  function automatic bit point_at(input int k, input int c, output int idx[4], output bit last);
    int t;
    bit ok;
    for (int i = 0; i < 4; i++) idx[i] = 0;
    last = 1'b0;
    if (c < cf_start[k]) return 1'b0;
    t = c - cf_start[k];
    if (cf_rep[k]) t = t % cf_per[k];
    ok = 1'b1;
    last = 1'b1;
    for (int i = 0; i < cf_nd[k]; i++) begin
      idx[i] = t / cf_s[k][i];
      t = t % cf_s[k][i];
      if (idx[i] >= cf_e[k][i]) ok = 1'b0;
      if (idx[i] != cf_e[k][i] - 1) last = 1'b0;
    end
    return ok && (t == 0);
  endfunction
  function automatic logic [63:0] pack(input int k, input int a[4]);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < cf_nd[k]; i++) p = p | (64'(a[i]) << ((cf_nd[k] - 1 - i) * 16));
    return p;
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mc[k] = 0;
      mf[k] = 1'b0;
      for (int i = 0; i < 4; i++) md[k][i] = 0;
    end
  endtask
  task automatic check_all();
    bit act, p, lst;
    int idx[4];
    int tmp[4];
    logic [63:0] ed;
    bit edn;
    act = en && !flush && rst_n;
    for (int k = 0; k < 4; k++) begin
      p = point_at(k, mc[k], idx, lst);
      h_hit[k] = act && p;
      h_last[k] = lst;
      for (int i = 0; i < 4; i++) begin
        h_idx[k][i] = idx[i];
        tmp[i] = md[k][i];
      end
      ed = h_hit[k] ? pack(k, idx) : pack(k, tmp);
      edn = cf_rep[k] ? (act && mf[k]) : mf[k];
      s_v[k] = v[k];
      s_dn[k] = dn[k];
      s_d[k] = dut_d[k];
      chk($sformatf("model_valid%0d", k), 64'(v[k]), 64'(h_hit[k]));
      chk($sformatf("model_done%0d", k), 64'(dn[k]), 64'(edn));
      chk($sformatf("model_d%0d", k), dut_d[k], ed);
    end
    if (tbl_on) begin
      if (v[0]) nv_a++;
      for (int j = 0; j < 12; j++) begin
        if (tbl[j].cyc == cyc) begin
          chk("tbl_a_valid", 64'(v[0]), 64'(tbl[j].av));
          chk("tbl_a_done", 64'(dn[0]), 64'(tbl[j].adn));
          chk("tbl_a_d", dut_d[0], 64'(tbl[j].ad));
          chk("tbl_b_valid", 64'(v[1]), 64'(tbl[j].bv));
          chk("tbl_b_done", 64'(dn[1]), 64'(tbl[j].bdn));
          chk("tbl_b_d", dut_d[1], 64'(tbl[j].bd));
        end
      end
    end
  endtask
  task automatic update();
    if (!rst_n) return;
    for (int k = 0; k < 4; k++) begin
      if (flush) begin
        mc[k] = 0;
        mf[k] = 1'b0;
        for (int i = 0; i < 4; i++) md[k][i] = 0;
      end else if (en) begin
        if (h_hit[k]) for (int i = 0; i < 4; i++) md[k][i] = h_idx[k][i];
        mf[k] = cf_rep[k] ? (h_hit[k] && h_last[k]) : (mf[k] || (h_hit[k] && h_last[k]));
        mc[k]++;
      end
    end
  endtask
  task automatic step(input bit e, input bit f);
    en = e;
    flush = f;
    @(negedge clk);
    check_all();
    @(posedge clk);
    update();
    #1 cyc++;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
  initial begin
    tbl[0]  = '{0,  1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0};
    tbl[1]  = '{5,  1'b1, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0};
    tbl[2]  = '{7,  1'b1, 1'b0, 32'h2,       1'b1, 1'b0, 32'h2};
    tbl[3]  = '{8,  1'b0, 1'b0, 32'h2,       1'b0, 1'b0, 32'h2};
    tbl[4]  = '{13, 1'b1, 1'b0, 32'h10000,   1'b1, 1'b0, 32'h10000};
    tbl[5]  = '{31, 1'b1, 1'b0, 32'h30002,   1'b1, 1'b0, 32'h30002};
    tbl[6]  = '{32, 1'b0, 1'b1, 32'h30002,   1'b0, 1'b1, 32'h30002};
    tbl[7]  = '{33, 1'b0, 1'b1, 32'h30002,   1'b0, 1'b0, 32'h30002};
    tbl[8]  = '{44, 1'b0, 1'b1, 32'h30002,   1'b0, 1'b0, 32'h30002};
    tbl[9]  = '{45, 1'b0, 1'b1, 32'h30002,   1'b1, 1'b0, 32'h0};
    tbl[10] = '{72, 1'b0, 1'b1, 32'h30002,   1'b0, 1'b1, 32'h30002};
    tbl[11] = '{73, 1'b0, 1'b1, 32'h30002,   1'b0, 1'b0, 32'h30002};
    do_reset();
    tbl_on = 1'b1;
    for (int i = 0; i < 80; i++) step(1'b1, 1'b0);
    tbl_on = 1'b0;
    chk("a_pulse_count", 64'(nv_a), 64'd12);
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step(!(i >= 6 && i <= 9), 1'b0);
      if (i == 7) begin
        chk("stall_valid", 64'(s_v[0]), 64'd0);
        chk("stall_d", s_d[0], 64'h0);
      end
      if (i == 10) begin
        chk("stall_resume_valid", 64'(s_v[0]), 64'd1);
        chk("stall_resume_d", s_d[0], 64'h1);
      end
      if (i == 35) chk("stall_last_d", s_d[0], 64'h30002);
      if (i == 36) chk("stall_done", 64'(s_dn[0]), 64'd1);
    end
    do_reset();
    for (int i = 0; i < 30; i++) begin
      step(1'b1, i == 20);
      if (i == 20) chk("flush_cycle_valid", 64'(s_v[0]), 64'd0);
      if (i == 21) begin
        chk("flush_c_restart_valid", 64'(s_v[2]), 64'd1);
        chk("flush_c_restart_d", s_d[2], 64'h0);
      end
      if (i == 25) chk("flush_a_wait", 64'(s_v[0]), 64'd0);
      if (i == 26) begin
        chk("flush_a_resume_valid", 64'(s_v[0]), 64'd1);
        chk("flush_a_resume_d", s_d[0], 64'h0);
      end
    end
    do_reset();
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0);
    rst_n = 1'b0;
    en = 1'b1;
    model_reset();
    #2;
    check_all();
    chk("rst_a_d", s_d[0], 64'h0);
    chk("rst_c_valid", 64'(s_v[2]), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0);
      if (i == 0) chk("rst_c_first", 64'(s_v[2]), 64'd1);
      if (i == 5) chk("rst_a_first", 64'(s_v[0]), 64'd1);
    end
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      step($urandom_range(0, 9) != 0, $urandom_range(0, 149) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
